// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with byte-enabled dual writeback,
// per-register busy scoreboard, outstanding-register counter and optional
// same-cycle write-to-read bypass.
module regfile_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra_addr,
    input  logic [AW-1:0]   rb_addr,
    output logic [DW-1:0]   ra_data,
    output logic [DW-1:0]   rb_data,
    output logic            ra_busy,
    output logic            rb_busy,
    input  logic            w0_en,
    input  logic [AW-1:0]   w0_addr,
    input  logic [DW-1:0]   w0_data,
    input  logic [DW/8-1:0] w0_be,
    input  logic            w1_en,
    input  logic [AW-1:0]   w1_addr,
    input  logic [DW-1:0]   w1_data,
    input  logic [DW/8-1:0] w1_be,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic [AW:0]     busy_cnt
);

    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             w0_ok;
    logic             w1_ok;
    logic             iss_ok;

    // True when the address is the hardwired zero register.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Overlay this cycle's enabled byte writes to address a onto old; port 1
    // is applied last so it wins on overlapping bytes.
    function automatic logic [DW-1:0] merge(
        input logic [DW-1:0]   old,
        input logic [AW-1:0]   a,
        input logic            e0,
        input logic [AW-1:0]   a0,
        input logic [DW-1:0]   d0,
        input logic [NB-1:0]   b0,
        input logic            e1,
        input logic [AW-1:0]   a1,
        input logic [DW-1:0]   d1,
        input logic [NB-1:0]   b1
    );
        logic [DW-1:0] v;
        v = old;
        for (int k = 0; k < NB; k++) begin
            if (e0 && (a0 == a) && b0[k]) v[8*k +: 8] = d0[8*k +: 8];
            if (e1 && (a1 == a) && b1[k]) v[8*k +: 8] = d1[8*k +: 8];
        end
        return v;
    endfunction

    // Number of set bits in the busy vector.
    function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) c = c + {{AW{1'b0}}, v[i]};
        return c;
    endfunction

    // Writes and issues aimed at the zero register are dropped up front.
    assign w0_ok  = w0_en  && !is_zero(w0_addr);
    assign w1_ok  = w1_en  && !is_zero(w1_addr);
    assign iss_ok = iss_en && !is_zero(iss_addr);

    // Byte-enabled data storage; the later port-1 assignment overrides port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (w0_ok && w0_be[k]) mem[w0_addr][8*k +: 8] <= w0_data[8*k +: 8];
                if (w1_ok && w1_be[k]) mem[w1_addr][8*k +: 8] <= w1_data[8*k +: 8];
            end
        end
    end

    // Next busy vector: writeback clears, then issue sets (new producer wins).
    always_comb begin
        busy_nxt = busy;
        if (w0_ok)  busy_nxt[w0_addr]  = 1'b0;
        if (w1_ok)  busy_nxt[w1_addr]  = 1'b0;
        if (iss_ok) busy_nxt[iss_addr] = 1'b1;
    end

    // Scoreboard state and its count advance together on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

    // Read port A: stored state, optionally with this cycle's writeback folded in.
    always_comb begin
        ra_data = mem[ra_addr];
        ra_busy = busy[ra_addr];
        if (BYPASS != 0) begin
            ra_data = merge(mem[ra_addr], ra_addr, w0_ok, w0_addr, w0_data, w0_be,
                            w1_ok, w1_addr, w1_data, w1_be);
            if (((w0_ok && w0_addr == ra_addr) || (w1_ok && w1_addr == ra_addr)) &&
                !(iss_ok && iss_addr == ra_addr))
                ra_busy = 1'b0;
        end
        if (is_zero(ra_addr)) begin
            ra_data = '0;
            ra_busy = 1'b0;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rb_data = mem[rb_addr];
        rb_busy = busy[rb_addr];
        if (BYPASS != 0) begin
            rb_data = merge(mem[rb_addr], rb_addr, w0_ok, w0_addr, w0_data, w0_be,
                            w1_ok, w1_addr, w1_data, w1_be);
            if (((w0_ok && w0_addr == rb_addr) || (w1_ok && w1_addr == rb_addr)) &&
                !(iss_ok && iss_addr == rb_addr))
                rb_busy = 1'b0;
        end
        if (is_zero(rb_addr)) begin
            rb_data = '0;
            rb_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus randomized traffic for regfile_sb,
// run on a bypassing zero-register instance and a plain instance in parallel.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra_addr, rb_addr;
    logic        w0_en, w1_en, iss_en;
    logic [4:0]  w0_addr, w1_addr, iss_addr;
    logic [31:0] w0_data, w1_data;
    logic [3:0]  w0_be, w1_be;

    logic [31:0] ra_d0, rb_d0, ra_d1, rb_d1;
    logic        ra_b0, rb_b0, ra_b1, rb_b1;
    logic [5:0]  cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: ZERO_REG=1, BYPASS=1.  Instance 1: ZERO_REG=0, BYPASS=0.
    regfile_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_d0), .rb_data(rb_d0), .ra_busy(ra_b0), .rb_busy(rb_b0),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data), .w0_be(w0_be),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data), .w1_be(w1_be),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(cnt0));

    regfile_sb #(.DW(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_d1), .rb_data(rb_d1), .ra_busy(ra_b1), .rb_busy(rb_b1),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data), .w0_be(w0_be),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data), .w1_be(w1_be),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(cnt1));

    // Reference model: index 0 mirrors dut, index 1 mirrors dut_b.
    logic [31:0] mm [2][32];
    logic [31:0] mb [2];

    function automatic bit zr(int i); return i == 0; endfunction
    function automatic bit bp(int i); return i == 0; endfunction

    function automatic bit h0(int i, logic [4:0] a);
        return w0_en && w0_addr == a && !(zr(i) && a == 0);
    endfunction
    function automatic bit h1(int i, logic [4:0] a);
        return w1_en && w1_addr == a && !(zr(i) && a == 0);
    endfunction
    function automatic bit hi(int i, logic [4:0] a);
        return iss_en && iss_addr == a && !(zr(i) && a == 0);
    endfunction

    // Value of register a once this cycle's writes (if mrg) are taken into account.
    function automatic logic [31:0] mval(int i, logic [4:0] a, bit mrg);
        logic [31:0] v;
        v = mm[i][a];
        if (mrg)
            for (int k = 0; k < 4; k++) begin
                if (h1(i, a) && w1_be[k])      v[8*k +: 8] = w1_data[8*k +: 8];
                else if (h0(i, a) && w0_be[k]) v[8*k +: 8] = w0_data[8*k +: 8];
            end
        return v;
    endfunction

    function automatic logic [31:0] exp_data(int i, logic [4:0] a);
        if (zr(i) && a == 0) return 32'h0;
        return mval(i, a, bp(i));
    endfunction

    function automatic logic exp_busy(int i, logic [4:0] a);
        if (zr(i) && a == 0) return 1'b0;
        if (bp(i) && (h0(i, a) || h1(i, a)) && !hi(i, a)) return 1'b0;
        return mb[i][a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mb[i] = '0;
            for (int a = 0; a < 32; a++) mm[i][a] = '0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++)
                for (int a = 0; a < 32; a++) begin
                    mm[i][a] = mval(i, 5'(a), 1'b1);
                    if (h0(i, 5'(a)) || h1(i, 5'(a))) mb[i][a] = 1'b0;
                    if (hi(i, 5'(a))) mb[i][a] = 1'b1;
                end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m0_ra_data", ra_d0, exp_data(0, ra_addr));
        chk("m0_rb_data", rb_d0, exp_data(0, rb_addr));
        chk("m0_ra_busy", {31'b0, ra_b0}, {31'b0, exp_busy(0, ra_addr)});
        chk("m0_rb_busy", {31'b0, rb_b0}, {31'b0, exp_busy(0, rb_addr)});
        chk("m0_busy_cnt", {26'b0, cnt0}, $countones(mb[0]));
        chk("m1_ra_data", ra_d1, exp_data(1, ra_addr));
        chk("m1_rb_data", rb_d1, exp_data(1, rb_addr));
        chk("m1_ra_busy", {31'b0, ra_b1}, {31'b0, exp_busy(1, ra_addr)});
        chk("m1_rb_busy", {31'b0, rb_b1}, {31'b0, exp_busy(1, rb_addr)});
        chk("m1_busy_cnt", {26'b0, cnt1}, $countones(mb[1]));
    endtask

    task automatic idle();
        rst = 0; w0_en = 0; w1_en = 0; iss_en = 0;
        w0_addr = 0; w1_addr = 0; iss_addr = 0;
        w0_data = 0; w1_data = 0; w0_be = 0; w1_be = 0;
    endtask

    // Compare outputs mid-cycle, then advance one edge and update the model.
    task automatic tick(input bit do_check);
        #2;
        if (do_check) model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            ra_addr = 5'(a);
            rb_addr = 5'(31 - a);
            #1;
            chk({tag, "_ra_data"}, ra_d0 | ra_d1, 32'h0);
            chk({tag, "_rb_data"}, rb_d0 | rb_d1, 32'h0);
            chk({tag, "_busy"}, {28'b0, ra_b0, rb_b0, ra_b1, rb_b1}, 32'h0);
        end
        chk({tag, "_cnt"}, {20'b0, cnt0, cnt1}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        w0e; logic [4:0] w0a; logic [31:0] w0d; logic [3:0] w0b;
        logic        w1e; logic [4:0] w1a; logic [31:0] w1d; logic [3:0] w1b;
        logic        ie;  logic [4:0] ia;
        logic [4:0]  ra;  logic [4:0] rb;
        logic [31:0] era; logic       erab;
        logic [31:0] erb; logic       erbb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vq[$];

    initial begin
        // Expected outputs of the bypassing zero-register instance, sampled
        // before the edge of each row.
        //            rst w0e w0a w0d           w0b   w1e w1a w1d           w1b   ie ia  ra  rb  era           erab erb          erbb cnt
        vq.push_back('{0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        4'h0, 0, 0,  5,  5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 0, 0,  5,  3, 32'hDEADBEEF, 0, 32'h0,        0, 0});
        vq.push_back('{0, 1, 3, 32'h11223344, 4'hF, 0, 0, 32'h0,        4'h0, 0, 0,  3,  5, 32'h11223344, 0, 32'hDEADBEEF, 0, 0});
        vq.push_back('{0, 1, 3, 32'hAABBCCDD, 4'h5, 0, 0, 32'h0,        4'h0, 0, 0,  3,  3, 32'h11BB33DD, 0, 32'h11BB33DD, 0, 0});
        vq.push_back('{0, 1, 7, 32'h0,        4'hF, 1, 7, 32'hFFFF0000, 4'hC, 0, 0,  3,  7, 32'h11BB33DD, 0, 32'hFFFF0000, 0, 0});
        vq.push_back('{0, 1, 7, 32'h0,        4'hF, 1, 7, 32'hFFFFFFFF, 4'h0, 0, 0,  7,  7, 32'h0,        0, 32'h0,        0, 0});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 1, 4,  7,  4, 32'h0,        0, 32'h0,        0, 0});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 1, 9,  4,  7, 32'h0,        1, 32'h0,        0, 1});
        vq.push_back('{0, 1, 4, 32'h00000044, 4'hF, 0, 0, 32'h0,        4'h0, 1, 4,  4,  9, 32'h00000044, 1, 32'h0,        1, 2});
        vq.push_back('{0, 1, 9, 32'h00000099, 4'hF, 0, 0, 32'h0,        4'h0, 0, 0,  4,  9, 32'h00000044, 1, 32'h00000099, 0, 2});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 0, 0,  4,  9, 32'h00000044, 1, 32'h00000099, 0, 1});
        vq.push_back('{0, 1, 6, 32'h0,        4'hF, 0, 0, 32'h0,        4'h0, 0, 0,  6,  6, 32'h0,        0, 32'h0,        0, 1});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 1, 6, 32'h12345678, 4'hF, 0, 0,  6,  3, 32'h12345678, 0, 32'h11BB33DD, 0, 1});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 0, 0,  6,  6, 32'h12345678, 0, 32'h12345678, 0, 1});
        vq.push_back('{0, 1, 0, 32'hFFFFFFFF, 4'hF, 1, 0, 32'hFFFFFFFF, 4'hF, 1, 0,  0,  0, 32'h0,        0, 32'h0,        0, 1});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 1, 10, 0,  4, 32'h0,        0, 32'h00000044, 1, 1});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 1, 11, 10, 0, 32'h0,        1, 32'h0,        0, 2});
        vq.push_back('{1, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 1, 2,  4, 11, 32'h00000044, 1, 32'h0,        1, 3});
        vq.push_back('{0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        4'h0, 0, 0,  4,  2, 32'h0,        0, 32'h0,        0, 0});

        // Reset with stray write/issue traffic that must be ignored.
        model_clear();
        idle();
        ra_addr = 0; rb_addr = 0;
        rst = 1; w0_en = 1; w0_addr = 8; w0_data = 32'hFFFFFFFF; w0_be = 4'hF;
        iss_en = 1; iss_addr = 8;
        #1;
        @(posedge clk);
        model_clear();
        #1;
        idle();
        read_all_zero("reset");

        // Directed vector table.
        foreach (vq[n]) begin
            rst = vq[n].rst;
            w0_en = vq[n].w0e; w0_addr = vq[n].w0a; w0_data = vq[n].w0d; w0_be = vq[n].w0b;
            w1_en = vq[n].w1e; w1_addr = vq[n].w1a; w1_data = vq[n].w1d; w1_be = vq[n].w1b;
            iss_en = vq[n].ie; iss_addr = vq[n].ia;
            ra_addr = vq[n].ra; rb_addr = vq[n].rb;
            #2;
            chk($sformatf("vec%0d_ra_data", n), ra_d0, vq[n].era);
            chk($sformatf("vec%0d_ra_busy", n), {31'b0, ra_b0}, {31'b0, vq[n].erab});
            chk($sformatf("vec%0d_rb_data", n), rb_d0, vq[n].erb);
            chk($sformatf("vec%0d_rb_busy", n), {31'b0, rb_b0}, {31'b0, vq[n].erbb});
            chk($sformatf("vec%0d_busy_cnt", n), {26'b0, cnt0}, {26'b0, vq[n].ecnt});
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end
        idle();
        read_all_zero("midreset");

        // Bypass versus no bypass on the same write.
        w1_en = 1; w1_addr = 6; w1_data = 32'h12345678; w1_be = 4'hF;
        ra_addr = 6; rb_addr = 6;
        #2;
        chk("bypass_on_data", ra_d0, 32'h12345678);
        chk("bypass_on_busy", {31'b0, ra_b0}, 32'h0);
        chk("bypass_off_data", ra_d1, 32'h0);
        tick(1'b1);
        idle();
        #2;
        chk("bypass_off_next", ra_d1, 32'h12345678);
        tick(1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bit narrow;
            narrow   = ($urandom_range(1) == 1);
            rst      = ($urandom_range(63) == 0);
            w0_en    = $urandom_range(1) == 1;
            w1_en    = $urandom_range(1) == 1;
            iss_en   = $urandom_range(2) != 0;
            w0_addr  = narrow ? 5'($urandom_range(3)) : 5'($urandom);
            w1_addr  = narrow ? 5'($urandom_range(3)) : 5'($urandom);
            iss_addr = narrow ? 5'($urandom_range(3)) : 5'($urandom);
            ra_addr  = narrow ? 5'($urandom_range(3)) : 5'($urandom);
            rb_addr  = 5'($urandom);
            w0_data  = $urandom;
            w1_data  = $urandom;
            w0_be    = 4'($urandom);
            w1_be    = 4'($urandom);
            tick(1'b1);
        end
        idle();
        tick(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
